// File: rtl/cvw_pkg.sv
// Shared trap-sequencer types: FSM state encoding, CSR write-select codes and trap targets.
package cvw_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WR_EPC     = 3'd1,
    WR_CAUSE   = 3'd2,
    WR_TVAL    = 3'd3,
    WR_STATUS  = 3'd4,
    RET_STATUS = 3'd5,
    REDIRECT   = 3'd6
  } trap_state_e;

  typedef enum logic [1:0] {
    TGT_NONE = 2'd0,
    TGT_M    = 2'd1,
    TGT_HS   = 2'd2,
    TGT_VS   = 2'd3
  } trap_tgt_e;

  localparam logic [2:0] SEL_EPC     = 3'd0;
  localparam logic [2:0] SEL_CAUSE   = 3'd1;
  localparam logic [2:0] SEL_TVAL    = 3'd2;
  localparam logic [2:0] SEL_STATUS  = 3'd3;
  localparam logic [2:0] SEL_RETSTAT = 3'd4;

endpackage

// File: rtl/trap_deleg.sv
// Combinational trap target resolution from delegation CSRs, privilege and V bit.
module trap_deleg
  import cvw_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            CauseInt,
  input  logic [5:0]      CauseCode,
  input  logic [1:0]      PrivilegeMode,
  input  logic            VirtMode,
  input  logic [XLEN-1:0] MEDELEG,
  input  logic [XLEN-1:0] MIDELEG,
  input  logic [XLEN-1:0] HEDELEG,
  input  logic [XLEN-1:0] HIDELEG,
  output trap_tgt_e       Target
);

  localparam int unsigned IW = $clog2(XLEN);
  // Cause-code bits that would index beyond the delegation registers
  localparam logic [5:0] HI_MASK = ~6'((64'(1) << IW) - 64'(1));

  logic [IW-1:0] idx;
  logic          in_range;
  logic          m_bit;
  logic          h_bit;
  logic          delegated;

  always_comb begin
    idx       = CauseCode[IW-1:0];
    in_range  = (CauseCode & HI_MASK) == 6'd0;
    m_bit     = CauseInt ? MIDELEG[idx] : MEDELEG[idx];
    h_bit     = CauseInt ? HIDELEG[idx] : HEDELEG[idx];
    delegated = in_range && m_bit && (PrivilegeMode != 2'b11);
    if (!delegated)
      Target = TGT_M;
    else if (VirtMode && h_bit)
      Target = TGT_VS;
    else
      Target = TGT_HS;
  end

endmodule

// File: rtl/trap_sequencer.sv
// Sequences trap-entry and return CSR writes, one write per handshake, then redirects.
// Optional TRAPSEQ_TVAL_EN adds the trap-value write state and its capture register.
module trap_sequencer
  import cvw_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            TrapReq,
  input  logic            RetReq,
  input  logic            RetIsS,
  input  logic            CauseInt,
  input  logic [5:0]      CauseCode,
  input  logic [1:0]      PrivilegeMode,
  input  logic            VirtMode,
  input  logic [XLEN-1:0] MEDELEG,
  input  logic [XLEN-1:0] MIDELEG,
  input  logic [XLEN-1:0] HEDELEG,
  input  logic [XLEN-1:0] HIDELEG,
  input  logic [XLEN-1:0] PCM,
  input  logic [XLEN-1:0] TvalIn,
  input  logic            CsrWrReady,
  output logic            CsrWrEn,
  output logic [2:0]      CsrWrSel,
  output logic [XLEN-1:0] CsrWrData,
  output logic            TrapToM,
  output logic            TrapToHS,
  output logic            TrapToVS,
  output logic            Busy,
  output logic            Done,
  output logic            DoneIsRet
);

  trap_state_e     state, state_next;
  trap_tgt_e       tgt, tgt_q;
  logic            accept_trap, accept_ret;
  logic [XLEN-1:0] pc_q;
  logic            cause_int_q;
  logic [5:0]      cause_code_q;
  logic [1:0]      priv_q;
  logic            virt_q;
  logic            is_ret_q;
  logic            ret_is_s_q;

  trap_deleg #(.XLEN(XLEN)) u_deleg (
    .CauseInt      (CauseInt),
    .CauseCode     (CauseCode),
    .PrivilegeMode (PrivilegeMode),
    .VirtMode      (VirtMode),
    .MEDELEG       (MEDELEG),
    .MIDELEG       (MIDELEG),
    .HEDELEG       (HEDELEG),
    .HIDELEG       (HIDELEG),
    .Target        (tgt)
  );

  assign accept_trap = (state == IDLE) && TrapReq;
  assign accept_ret  = (state == IDLE) && !TrapReq && RetReq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Request context is frozen at acceptance so mid-sequence input changes are ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= '0;
      cause_int_q  <= 1'b0;
      cause_code_q <= '0;
      priv_q       <= '0;
      virt_q       <= 1'b0;
      tgt_q        <= TGT_NONE;
      is_ret_q     <= 1'b0;
      ret_is_s_q   <= 1'b0;
    end else if (accept_trap) begin
      pc_q         <= PCM;
      cause_int_q  <= CauseInt;
      cause_code_q <= CauseCode;
      priv_q       <= PrivilegeMode;
      virt_q       <= VirtMode;
      tgt_q        <= tgt;
      is_ret_q     <= 1'b0;
    end else if (accept_ret) begin
      tgt_q        <= TGT_NONE;
      is_ret_q     <= 1'b1;
      ret_is_s_q   <= RetIsS;
    end
  end

`ifdef TRAPSEQ_TVAL_EN
  logic [XLEN-1:0] tval_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            tval_q <= '0;
    else if (accept_trap) tval_q <= TvalIn;
  end
`else
  logic unused_tval;
  assign unused_tval = ^TvalIn;
`endif

  always_comb begin
    state_next = state;
    CsrWrEn    = 1'b0;
    CsrWrSel   = SEL_EPC;
    CsrWrData  = '0;
    Done       = 1'b0;
    DoneIsRet  = 1'b0;
    case (state)
      IDLE: begin
        if (TrapReq)     state_next = WR_EPC;
        else if (RetReq) state_next = RET_STATUS;
      end
      WR_EPC: begin
        CsrWrEn   = 1'b1;
        CsrWrSel  = SEL_EPC;
        CsrWrData = pc_q;
        if (CsrWrReady) state_next = WR_CAUSE;
      end
      WR_CAUSE: begin
        CsrWrEn   = 1'b1;
        CsrWrSel  = SEL_CAUSE;
        CsrWrData = {cause_int_q, {(XLEN-7){1'b0}}, cause_code_q};
`ifdef TRAPSEQ_TVAL_EN
        if (CsrWrReady) state_next = WR_TVAL;
`else
        if (CsrWrReady) state_next = WR_STATUS;
`endif
      end
      WR_TVAL: begin
`ifdef TRAPSEQ_TVAL_EN
        CsrWrEn   = 1'b1;
        CsrWrSel  = SEL_TVAL;
        CsrWrData = tval_q;
        if (CsrWrReady) state_next = WR_STATUS;
`else
        state_next = IDLE;
`endif
      end
      WR_STATUS: begin
        CsrWrEn   = 1'b1;
        CsrWrSel  = SEL_STATUS;
        CsrWrData = {{(XLEN-3){1'b0}}, virt_q, priv_q};
        if (CsrWrReady) state_next = REDIRECT;
      end
      RET_STATUS: begin
        CsrWrEn   = 1'b1;
        CsrWrSel  = SEL_RETSTAT;
        CsrWrData = {{(XLEN-1){1'b0}}, ret_is_s_q};
        if (CsrWrReady) state_next = REDIRECT;
      end
      REDIRECT: begin
        Done       = 1'b1;
        DoneIsRet  = is_ret_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign Busy     = (state != IDLE);
  assign TrapToM  = Busy && !is_ret_q && (tgt_q == TGT_M);
  assign TrapToHS = Busy && !is_ret_q && (tgt_q == TGT_HS);
  assign TrapToVS = Busy && !is_ret_q && (tgt_q == TGT_VS);

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: directed traps/returns, stalls, and mid-sequence reset.
module tb_trap_sequencer;
  import cvw_pkg::*;

`ifdef TRAPSEQ_TVAL_EN
  localparam int TRAP_LAT = 5;
`else
  localparam int TRAP_LAT = 4;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        TrapReq, RetReq, RetIsS, CauseInt, VirtMode, CsrWrReady;
  logic [5:0]  CauseCode;
  logic [1:0]  PrivilegeMode;
  logic [63:0] MEDELEG, MIDELEG, HEDELEG, HIDELEG, PCM, TvalIn;
  logic        CsrWrEn, TrapToM, TrapToHS, TrapToVS, Busy, Done, DoneIsRet;
  logic [2:0]  CsrWrSel;
  logic [63:0] CsrWrData;

  trap_sequencer #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .TrapReq(TrapReq), .RetReq(RetReq), .RetIsS(RetIsS),
    .CauseInt(CauseInt), .CauseCode(CauseCode), .PrivilegeMode(PrivilegeMode),
    .VirtMode(VirtMode), .MEDELEG(MEDELEG), .MIDELEG(MIDELEG), .HEDELEG(HEDELEG),
    .HIDELEG(HIDELEG), .PCM(PCM), .TvalIn(TvalIn), .CsrWrReady(CsrWrReady),
    .CsrWrEn(CsrWrEn), .CsrWrSel(CsrWrSel), .CsrWrData(CsrWrData),
    .TrapToM(TrapToM), .TrapToHS(TrapToHS), .TrapToVS(TrapToVS),
    .Busy(Busy), .Done(Done), .DoneIsRet(DoneIsRet)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    logic [2:0]  sel;
    logic [63:0] data;
    int          hold;
    logic        ret;
    logic [2:0]  tgt;   // {M, HS, VS}
    int          lat;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [2:0] sel, input logic [63:0] data, input int hold);
    exp_t e;
    e = '{is_done: 1'b0, sel: sel, data: data, hold: hold, ret: 1'b0, tgt: 3'b000, lat: 0};
    q.push_back(e);
  endtask

  task automatic push_done(input logic ret, input logic [2:0] tgt, input int lat);
    exp_t e;
    e = '{is_done: 1'b1, sel: 3'd0, data: 64'd0, hold: 0, ret: ret, tgt: tgt, lat: lat};
    q.push_back(e);
  endtask

  task automatic push_trap(input logic [63:0] pc, input logic [63:0] cause, input logic [63:0] tv,
                           input logic [63:0] status, input logic [2:0] tgt);
    push_wr(SEL_EPC, pc, 1);
    push_wr(SEL_CAUSE, cause, 1);
`ifdef TRAPSEQ_TVAL_EN
    push_wr(SEL_TVAL, tv, 1);
`else
    if (tv == 64'hFFFF_FFFF_FFFF_FFFF) $display("note: tval unused");
`endif
    push_wr(SEL_STATUS, status, 1);
    push_done(1'b0, tgt, TRAP_LAT);
  endtask

  // Monitor: pops the scoreboard on every CSR handshake and every Done pulse
  int          en_cnt = 0;
  int          lat_cnt = 0;
  bit          stall = 0;
  logic [2:0]  prev_sel;
  logic [63:0] prev_data;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      en_cnt = 0; lat_cnt = 0; stall = 0;
    end else begin
      if (Busy) lat_cnt++; else lat_cnt = 0;
      if (CsrWrEn) begin
        en_cnt++;
        if (stall) begin
          check("stall_sel_stable", 64'(CsrWrSel), 64'(prev_sel));
          check("stall_data_stable", CsrWrData, prev_data);
        end
        if (CsrWrReady) begin
          if (q.size() == 0) begin
            check("unexpected_write_sel", 64'(CsrWrSel), 64'hFFFF);
          end else begin
            e = q.pop_front();
            check("write_vs_done_order", 64'(e.is_done), 64'd0);
            check("write_sel", 64'(CsrWrSel), 64'(e.sel));
            check("write_data", CsrWrData, e.data);
            check("write_hold_cycles", 64'(en_cnt), 64'(e.hold));
          end
          en_cnt = 0; stall = 0;
        end else begin
          stall = 1; prev_sel = CsrWrSel; prev_data = CsrWrData;
        end
      end
      if (Done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 64'(Done), 64'd0);
        end else begin
          e = q.pop_front();
          check("done_vs_write_order", 64'(e.is_done), 64'd1);
          check("done_is_ret", 64'(DoneIsRet), 64'(e.ret));
          check("done_target", 64'({TrapToM, TrapToHS, TrapToVS}), 64'(e.tgt));
          check("done_latency", 64'(lat_cnt), 64'(e.lat));
        end
      end
    end
  end

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk); #1;
      if (!Busy) ok = 1;
    end
    RetReq = 1'b0;
    check("sequence_returns_idle", 64'(Busy), 64'd0);
  endtask

  // Issue a trap, then scramble every input so only latched values can be seen
  task automatic run_trap(input logic ci, input logic [5:0] cc, input logic [1:0] pv, input logic vm,
                          input logic [63:0] med, input logic [63:0] mid, input logic [63:0] hed,
                          input logic [63:0] hid, input logic [63:0] pc, input logic [63:0] tv,
                          input logic also_ret);
    CauseInt = ci; CauseCode = cc; PrivilegeMode = pv; VirtMode = vm;
    MEDELEG = med; MIDELEG = mid; HEDELEG = hed; HIDELEG = hid;
    PCM = pc; TvalIn = tv; CsrWrReady = 1'b1;
    TrapReq = 1'b1; RetReq = also_ret; RetIsS = 1'b1;
    @(posedge clk); #1;
    TrapReq = 1'b0; RetReq = 1'b1;
    CauseInt = ~ci; CauseCode = cc ^ 6'h3F; PrivilegeMode = ~pv; VirtMode = ~vm;
    MEDELEG = ~med; MIDELEG = ~mid; HEDELEG = ~hed; HIDELEG = ~hid;
    PCM = ~pc; TvalIn = ~tv;
    wait_idle();
  endtask

  task automatic run_ret(input logic is_s, input int stall_cycles);
    RetReq = 1'b1; RetIsS = is_s; CsrWrReady = (stall_cycles == 0);
    @(posedge clk); #1;
    RetReq = 1'b0; RetIsS = ~is_s;
    if (stall_cycles > 0) begin
      repeat (stall_cycles) @(posedge clk);
      #1 CsrWrReady = 1'b1;
    end
    wait_idle();
  endtask

  initial begin
    reset = 1'b1; TrapReq = 0; RetReq = 0; RetIsS = 0; CauseInt = 0; CauseCode = '0;
    PrivilegeMode = '0; VirtMode = 0; MEDELEG = '0; MIDELEG = '0; HEDELEG = '0; HIDELEG = '0;
    PCM = '0; TvalIn = '0; CsrWrReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(Busy), 64'd0);
    check("reset_csr_en", 64'(CsrWrEn), 64'd0);
    check("reset_done", 64'(Done), 64'd0);
    check("reset_trap_to", 64'({TrapToM, TrapToHS, TrapToVS}), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", 64'(Busy), 64'd0);
    check("idle_csr_en", 64'(CsrWrEn), 64'd0);

    // U-mode exception, not delegated -> M
    push_trap(64'h8000_1000, 64'h2, 64'hDEAD, 64'h0, 3'b100);
    run_trap(1'b0, 6'd2, 2'b00, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h8000_1000, 64'hDEAD, 1'b0);

    // Virtualised U-mode, delegated twice -> VS, status {V=1, priv=0}
    push_trap(64'h2000, 64'h8, 64'h55, 64'h4, 3'b001);
    run_trap(1'b0, 6'd8, 2'b00, 1'b1, 64'h100, 64'h0, 64'h100, 64'h0, 64'h2000, 64'h55, 1'b0);

    // S-mode interrupt delegated by MIDELEG, V=0 -> HS
    push_trap(64'h3000, 64'h8000_0000_0000_0005, 64'h0, 64'h1, 3'b010);
    run_trap(1'b1, 6'd5, 2'b01, 1'b0, 64'h0, 64'h20, 64'h0, 64'h20, 64'h3000, 64'h0, 1'b0);

    // Simultaneous trap and return: trap wins, no RETSTAT write
    push_trap(64'h4000, 64'h3, 64'h77, 64'h3, 3'b100);
    run_trap(1'b0, 6'd3, 2'b11, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h4000, 64'h77, 1'b1);

    // M-mode trap ignores delegation
    push_trap(64'h5000, 64'h2, 64'h1, 64'h3, 3'b100);
    run_trap(1'b0, 6'd2, 2'b11, 1'b0, '1, '1, '1, '1, 64'h5000, 64'h1, 1'b0);

    // sret with three stalled cycles
    push_wr(SEL_RETSTAT, 64'h1, 4);
    push_done(1'b1, 3'b000, 5);
    run_ret(1'b1, 3);

    // mret, no stall
    push_wr(SEL_RETSTAT, 64'h0, 1);
    push_done(1'b1, 3'b000, 2);
    run_ret(1'b0, 0);

    // Reset while stalled in WR_CAUSE: only the EPC write may complete
    push_wr(SEL_EPC, 64'h6000, 1);
    CauseInt = 0; CauseCode = 6'd4; PrivilegeMode = 2'b00; VirtMode = 0;
    MEDELEG = '0; MIDELEG = '0; HEDELEG = '0; HIDELEG = '0;
    PCM = 64'h6000; TvalIn = 64'h9; CsrWrReady = 1'b1; TrapReq = 1'b1;
    @(posedge clk); #1;
    TrapReq = 1'b0;
    @(posedge clk); #1;
    CsrWrReady = 1'b0;
    check("pre_reset_sel_cause", 64'(CsrWrSel), 64'(SEL_CAUSE));
    check("pre_reset_trap_to_m", 64'(TrapToM), 64'd1);
    #1 reset = 1'b1;
    #1;
    check("mid_reset_busy", 64'(Busy), 64'd0);
    check("mid_reset_csr_en", 64'(CsrWrEn), 64'd0);
    check("mid_reset_csr_sel", 64'(CsrWrSel), 64'd0);
    check("mid_reset_csr_data", CsrWrData, 64'd0);
    check("mid_reset_done", 64'({Done, DoneIsRet}), 64'd0);
    check("mid_reset_trap_to", 64'({TrapToM, TrapToHS, TrapToVS}), 64'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0; CsrWrReady = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_reset_busy", 64'(Busy), 64'd0);
    check("scoreboard_drained", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
